// File: rtl/vga_fb_scanout.sv
// 160x120x3 frame buffer with an independent plot write port, scanned out as
// 640x480@60 VGA with each stored pixel replicated 4x4.
module vga_fb_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [7:0] vga_x,
    input  logic [6:0] vga_y,
    input  logic [2:0] vga_colour,
    input  logic       vga_plot,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_start
);

    localparam int XRES       = 160;
    localparam int YRES       = 120;
    localparam int SCALE_LOG2 = 2;

    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    logic        r_pix_en;
    logic        r_vga_clk;
    logic [9:0]  r_hcnt;
    logic [9:0]  r_vcnt;
    logic [14:0] r_addr;
    logic        r_vis1, r_hs1, r_vs1;
    logic        r_vis2, r_hs2, r_vs2;
    logic        r_frame_start;
    logic [2:0]  r_rdata;
    logic [2:0]  r_mem [0:XRES*YRES-1];

    logic        w_wr_en;
    logic [14:0] w_waddr;
    logic [9:0]  w_fx, w_fy;
    logic [14:0] w_raddr;
    logic        w_vis, w_hs_n, w_vs_n;
    logic        w_h_last, w_v_last;

    always_comb begin
        // Row stride of 160 built from shifts: y*128 + y*32.
        w_wr_en  = vga_plot && (vga_x < 8'(XRES)) && (vga_y < 7'(YRES));
        w_waddr  = (15'(vga_y) << 7) + (15'(vga_y) << 5) + 15'(vga_x);
        w_fx     = r_hcnt >> SCALE_LOG2;
        w_fy     = r_vcnt >> SCALE_LOG2;
        w_raddr  = (15'(w_fy) << 7) + (15'(w_fy) << 5) + 15'(w_fx);
        w_vis    = (r_hcnt < H_VIS_L) && (r_vcnt < V_VIS_L);
        w_hs_n   = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
        w_vs_n   = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
        w_h_last = (r_hcnt == H_LAST);
        w_v_last = (r_vcnt == V_LAST);
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            r_pix_en      <= 1'b0;
            r_vga_clk     <= 1'b0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_addr        <= '0;
            r_vis1        <= 1'b0;
            r_hs1         <= 1'b1;
            r_vs1         <= 1'b1;
            r_vis2        <= 1'b0;
            r_hs2         <= 1'b1;
            r_vs2         <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_en      <= ~r_pix_en;
            r_vga_clk     <= r_pix_en;
            r_frame_start <= 1'b0;
            if (r_pix_en) begin
                if (w_h_last) begin
                    r_hcnt <= '0;
                    r_vcnt <= w_v_last ? '0 : r_vcnt + 10'd1;
                end else begin
                    r_hcnt <= r_hcnt + 10'd1;
                end
                r_frame_start <= w_h_last && w_v_last;
                r_addr <= w_raddr;
                r_vis1 <= w_vis;
                r_hs1  <= w_hs_n;
                r_vs1  <= w_vs_n;
                r_vis2 <= r_vis1;
                r_hs2  <= r_hs1;
                r_vs2  <= r_vs1;
            end
        end
    end

    // Unreset so it maps onto block RAM; a same-edge read returns old data.
    always_ff @(posedge CLOCK_50) begin
        if (w_wr_en)
            r_mem[w_waddr] <= vga_colour;
        if (r_pix_en)
            r_rdata <= r_mem[r_addr];
    end

    assign VGA_CLK     = r_vga_clk;
    assign VGA_HS      = r_hs2;
    assign VGA_VS      = r_vs2;
    assign VGA_BLANK_N = r_vis2;
    assign VGA_R       = {8{r_vis2 & r_rdata[2]}};
    assign VGA_G       = {8{r_vis2 & r_rdata[1]}};
    assign VGA_B       = {8{r_vis2 & r_rdata[0]}};
    assign frame_start = r_frame_start;

endmodule
